// File: rtl/n64_pif_si_dma.sv
// SI-side DMA sequencer that moves one 64-byte PIF RAM command block between a
// 32-bit stream and the PIF RAM word port, in either direction.
module n64_pif_si_dma #(
  parameter int                WORDS     = 16,
  parameter int                RAM_AW    = 9,
  parameter logic [RAM_AW-1:0] BASE_WORD = 9'h1F0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              dir,
  input  logic              pif_busy,
  output logic              busy,
  output logic              done,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_wren,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic [31:0]       s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [31:0]       m_data,
  output logic              m_valid,
  input  logic              m_ready
);

  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WAIT    = 3'd1;
  localparam logic [2:0] WR      = 3'd2;
  localparam logic [2:0] RD_ADDR = 3'd3;
  localparam logic [2:0] RD_LAT  = 3'd4;
  localparam logic [2:0] RD_OUT  = 3'd5;
  localparam logic [2:0] FIN     = 3'd6;

  logic [2:0]        state;
  logic              dir_q;
  logic [CW-1:0]     cnt;
  logic [RAM_AW-1:0] word_addr;

  assign word_addr = BASE_WORD + RAM_AW'(cnt);

  // Both streams use valid/ready: a word moves on a rising edge where valid
  // and ready are both high; a source holds data stable until then.
  assign s_ready = (state == WR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      dir_q     <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ram_wren  <= 1'b0;
      ram_addr  <= BASE_WORD;
      ram_wdata <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
    end else begin
      done     <= 1'b0;
      ram_wren <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dir_q <= dir;
            busy  <= 1'b1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!pif_busy) begin
            cnt      <= '0;
            ram_addr <= BASE_WORD;
            state    <= dir_q ? WR : RD_ADDR;
          end
        end
        WR: begin
          if (s_valid) begin
            ram_wren  <= 1'b1;
            ram_wdata <= s_data;
            ram_addr  <= word_addr;
            if (cnt == LAST) begin
              cnt   <= '0;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        RD_ADDR: begin
          ram_addr <= word_addr;
          state    <= RD_LAT;
        end
        RD_LAT: begin
          m_data  <= ram_rdata;
          m_valid <= 1'b1;
          state   <= RD_OUT;
        end
        RD_OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (cnt == LAST) begin
              cnt   <= '0;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              // Present the next address on entry to RD_ADDR so the registered
              // RAM output is ready by the end of RD_LAT.
              cnt      <= cnt + 1'b1;
              ram_addr <= word_addr + RAM_AW'(1);
              state    <= RD_ADDR;
            end
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
